// File: rtl/mac_dot_seq.sv
// Streams signed operand pairs through one mac_unit and accumulates
// bias + sum(a*b). The result is saturated to 32 bits and handed off over valid/ready.
// Ports:
//   clk, rst_n (async, active-low)
//   start, len, bias, busy                     : job request and status
//   in_valid, in_ready, in_a, in_b             : operand stream
//   res_valid, res_ready, res_data, res_sat    : result stream
module mac_unit (
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic [15:0] in_c,
  output logic [31:0] mac_out
);
  logic signed [31:0] a_x;
  logic signed [31:0] b_x;
  logic signed [31:0] c_x;

  // Widen both operands before multiplying so that -32768*-32768 = +2^30.
  assign a_x = $signed({{16{in_a[15]}}, in_a});
  assign b_x = $signed({{16{in_b[15]}}, in_b});
  assign c_x = $signed({{16{in_c[15]}}, in_c});
  assign mac_out = a_x * b_x + c_x;
endmodule

module mac_dot_seq #(
  parameter int LEN_W = 8,
  parameter int ACC_W = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [15:0]      bias,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic             res_sat
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             first_q, first_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [15:0]      bias_q, bias_d;
  logic [31:0]      res_data_q, res_data_d;
  logic             res_sat_q, res_sat_d;

  logic [15:0]      mac_c;
  logic [31:0]      mac_out;
  logic [ACC_W-1:0] mac_ext;
  logic [LEN_W-1:0] cnt_inc;
  logic             load_res;
  logic [ACC_W-32:0] acc_hi;

  // Bias enters through the MAC's addend on the first beat only.
  assign mac_c = first_q ? bias_q : 16'd0;

  mac_unit u_mac (
    .in_a    (in_a),
    .in_b    (in_b),
    .in_c    (mac_c),
    .mac_out (mac_out)
  );

  assign mac_ext = {{(ACC_W-32){mac_out[31]}}, mac_out};
  assign cnt_inc = cnt_q + LEN_W'(1);
  assign acc_hi  = acc_d[ACC_W-1:31];

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    first_d    = first_q;
    len_d      = len_q;
    bias_d     = bias_q;
    res_data_d = res_data_q;
    res_sat_d  = res_sat_q;
    load_res   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len != '0) begin
            len_d   = len;
            bias_d  = bias;
            acc_d   = '0;
            cnt_d   = '0;
            first_d = 1'b1;
            state_d = ST_RUN;
          end else begin
            acc_d    = {{(ACC_W-16){bias[15]}}, bias};
            state_d  = ST_DONE;
            load_res = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (in_valid) begin
          acc_d   = acc_q + mac_ext;
          first_d = 1'b0;
          cnt_d   = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d  = ST_DONE;
            load_res = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Value fits in 32 bits iff bits [ACC_W-1:31] are all equal.
    if (load_res) begin
      if ((&acc_hi) || !(|acc_hi)) begin
        res_data_d = acc_d[31:0];
        res_sat_d  = 1'b0;
      end else if (acc_d[ACC_W-1]) begin
        res_data_d = 32'h8000_0000;
        res_sat_d  = 1'b1;
      end else begin
        res_data_d = 32'h7FFF_FFFF;
        res_sat_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      first_q    <= 1'b0;
      len_q      <= '0;
      bias_q     <= '0;
      res_data_q <= '0;
      res_sat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      first_q    <= first_d;
      len_q      <= len_d;
      bias_q     <= bias_d;
      res_data_q <= res_data_d;
      res_sat_q  <= res_sat_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign in_ready  = (state_q == ST_RUN);
  assign res_valid = (state_q == ST_DONE);
  assign res_data  = res_data_q;
  assign res_sat   = res_sat_q;
endmodule

// File: tb/tb_mac_dot_seq.sv
// Directed and random checks of mac_dot_seq against a plain-arithmetic
// dot-product model.
module tb_mac_dot_seq;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic [15:0] bias;
  logic        busy;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_sat;

  int checks = 0;
  int errors = 0;

  int qa[$];
  int qb[$];
  int qg[$];

  mac_dot_seq #(.LEN_W(8), .ACC_W(40)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .bias      (bias),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_sat   (res_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: bias + sum(a*b) in 64-bit arithmetic, clipped to int32.
  task automatic model(input int bs, output logic [31:0] d,
                       output logic s);
    longint sum;
    sum = longint'(bs);
    foreach (qa[i]) sum += longint'(qa[i]) * longint'(qb[i]);
    if (sum > 64'sd2147483647) begin
      d = 32'h7FFF_FFFF; s = 1'b1;
    end else if (sum < -64'sd2147483648) begin
      d = 32'h8000_0000; s = 1'b1;
    end else begin
      d = 32'(sum); s = 1'b0;
    end
  endtask

  // Runs one job from the queues; gaps in qg, result held for hold cycles.
  // A start pulse is injected while busy when poke is set.
  task automatic run_case(input string tag, input int bs, input int hold,
                          input bit poke);
    logic [31:0] ed;
    logic        es;
    model(bs, ed, es);
    start = 1'b1;
    len   = 8'(qa.size());
    bias  = 16'(bs);
    @(negedge clk);
    start = 1'b0;
    foreach (qa[i]) begin
      for (int g = 0; g < qg[i]; g++) begin
        in_valid = 1'b0;
        if (poke && g == 0) begin
          start = 1'b1; len = 8'd1; bias = 16'h7FFF;
        end
        @(negedge clk);
        start = 1'b0;
      end
      check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      in_a = 16'(qa[i]);
      in_b = 16'(qb[i]);
      @(negedge clk);
      in_valid = 1'b0;
      in_a = $urandom;
      in_b = $urandom;
    end
    check({tag, "_valid"}, 64'(res_valid), 64'd1);
    check({tag, "_in_ready_done"}, 64'(in_ready), 64'd0);
    check({tag, "_data"}, 64'(res_data), 64'(ed));
    check({tag, "_sat"}, 64'(res_sat), 64'(es));
    for (int h = 0; h < hold; h++) begin
      res_ready = 1'b0;
      start = poke;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_hold_valid"}, 64'(res_valid), 64'd1);
      check({tag, "_hold_data"}, 64'(res_data), 64'(ed));
    end
    // start coinciding with the handshake must be ignored
    res_ready = 1'b1;
    start = poke;
    len = 8'd2;
    @(negedge clk);
    res_ready = 1'b0;
    start = 1'b0;
    check({tag, "_valid_fall"}, 64'(res_valid), 64'd0);
    check({tag, "_busy_fall"}, 64'(busy), 64'd0);
    check({tag, "_data_kept"}, 64'(res_data), 64'(ed));
    qa.delete(); qb.delete(); qg.delete();
  endtask

  task automatic push(input int a, input int b, input int g);
    qa.push_back(a); qb.push_back(b); qg.push_back(g);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_valid"}, 64'(res_valid), 64'd0);
    check({tag, "_data"}, 64'(res_data), 64'd0);
    check({tag, "_sat"}, 64'(res_sat), 64'd0);
  endtask

  initial begin
    int n;
    int bs;
    rst_n = 1'b0; start = 1'b0; len = '0; bias = '0;
    in_valid = 1'b0; in_a = '0; in_b = '0; res_ready = 1'b0;
    #1;
    check_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("post_reset");

    push(2, 3, 0); push(4, -1, 0); push(-7, 6, 0);
    run_case("basic", 5, 1, 1'b0);
    check("basic_const", 64'(res_data), 64'hFFFF_FFDD);

    // len=0: result straight from bias, no operand phase
    start = 1'b1; len = 8'd0; bias = 16'hFFFE;
    @(negedge clk);
    start = 1'b0;
    check("len0_valid", 64'(res_valid), 64'd1);
    check("len0_in_ready", 64'(in_ready), 64'd0);
    check("len0_data", 64'(res_data), 64'hFFFF_FFFE);
    check("len0_sat", 64'(res_sat), 64'd0);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("len0_fall", 64'(res_valid), 64'd0);

    for (int i = 0; i < 4; i++) push(-32768, -32768, 0);
    run_case("satpos", 0, 0, 1'b0);
    check("satpos_const", 64'({res_sat, res_data}), 64'h1_7FFF_FFFF);

    push(-32768, 32767, 0); push(-32768, 32767, 0);
    run_case("nearneg", 0, 0, 1'b0);
    check("nearneg_const", 64'({res_sat, res_data}), 64'h0_8001_0000);

    push(1, 1, 0); push(1, 1, 2); push(1, 1, 4);
    run_case("gaps", 1, 5, 1'b1);
    check("gaps_const", 64'(res_data), 64'd4);

    push(-3, 9, 0);
    run_case("after_gaps", 10, 0, 1'b0);
    check("after_gaps_const", 64'(res_data), 64'hFFFF_FFEF);

    // reset mid-run
    start = 1'b1; len = 8'd5; bias = 16'd9;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_a = 16'd100; in_b = 16'd100;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("midreset_rel");
    push(3, 7, 0);
    run_case("post_mid", 0, 0, 1'b0);
    check("post_mid_const", 64'(res_data), 64'd21);

    // random jobs, with extreme operands mixed in
    for (int t = 0; t < 25; t++) begin
      n = $urandom_range(1, 9);
      bs = int'($signed(16'($urandom)));
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0)
          push(-32768, ($urandom_range(0, 1) != 0) ? -32768 : 32767,
               $urandom_range(0, 2));
        else
          push(int'($signed(16'($urandom))), int'($signed(16'($urandom))),
               $urandom_range(0, 2));
      end
      run_case("rand", bs, $urandom_range(0, 2), ($urandom_range(0, 1) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mac_dot_seq.md
Name: mac_dot_seq

Overview:
- Sequential controller that streams operand pairs through one `mac_unit` instance and accumulates a signed dot product of programmable length: result = bias + Σ a[i]*b[i].
- Sits between an operand source (valid/ready stream) and a result consumer (valid/ready).
- Owns the only `mac_unit` in its datapath; provides wide accumulation and saturation to 32 bits.

Parameters:
- LEN_W, 8, width of the element-count field; maximum vector length 2^LEN_W-1.
- ACC_W, 40, internal accumulator width in bits; must be ≥ 32+LEN_W-1 so that no internal wrap occurs.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a dot product; honoured only in IDLE.
- len  input  LEN_W  element count, sampled when start is accepted.
- bias  input  16  signed bias, sampled when start is accepted.
- busy  output  1  high whenever state ≠ IDLE.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  high only in RUN.
- in_a  input  16  signed operand a.
- in_b  input  16  signed operand b.
- res_valid  output  1  result valid; high only in DONE.
- res_ready  input  1  consumer accepts the result.
- res_data  output  32  signed saturated result.
- res_sat  output  1  high when res_data was clipped.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, acc=0, cnt=0, first=0, len_q=0, bias_q=0.
  - Outputs at reset: busy=0, in_ready=0, res_valid=0, res_data=0, res_sat=0.
  - Reset asserted mid-run discards all state; no partial result is emitted.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 and len≠0: latch len_q=len, bias_q=bias, set acc=0, cnt=0, first=1; next state RUN.
  - start=1 and len=0: set acc=sext(bias); next state DONE. res_valid rises the cycle after start.
  - start=0: remain in IDLE.
- RUN:
  - in_ready=1. A beat is accepted on a cycle with in_valid & in_ready.
  - `mac_unit` connections: in_a→in_a, in_b→in_b, in_c = first ? bias_q : 16'd0.
  - On an accepted beat: acc ← acc + sext(mac_out) to ACC_W bits; first←0; cnt←cnt+1.
  - When the accepted beat has cnt==len_q-1, the next state is DONE.
  - Cycles with in_valid=0 leave acc, cnt and first unchanged (gaps allowed).
  - Throughput: one beat per cycle.
- DONE:
  - res_valid=1. res_data and res_sat are registered values, computed from acc on entry to DONE:
    - acc > 2^31-1 → res_data=32'h7FFFFFFF, res_sat=1.
    - acc < -2^31 → res_data=32'h80000000, res_sat=1.
    - otherwise → res_data=acc[31:0], res_sat=0.
  - res_data and res_sat are held stable while res_ready=0.
  - res_valid & res_ready → next state IDLE; res_valid falls next cycle. res_data and res_sat keep their last value.
- Latency: res_valid asserts the cycle after the last beat is accepted.
- start while busy=1: ignored, no side effects.
- in_valid while not in RUN: ignored; in_ready=0.
- start in the same cycle as the DONE handshake: ignored, because state is not IDLE in that cycle.
- Arithmetic:
  - All signed, two's complement.
  - mac_out is the 32-bit `mac_unit` result.
  - The product for -32768 × -32768 is +2^30 and must not wrap.

Test Plan:
- len=3, bias=5, pairs (2,3),(4,-1),(-7,6) on consecutive cycles → res_valid one cycle after 3rd beat; res_data=32'hFFFFFFDD (-35); res_sat=0.
- len=0, bias=-2 → res_valid the cycle after start; res_data=32'hFFFFFFFE; in_ready never high.
- len=4, bias=0, four pairs (-32768,-32768) → sum 2^32; res_data=32'h7FFFFFFF, res_sat=1.
- len=2, bias=0, pairs (-32768,32767),(-32768,32767) → res_data=32'h80010000 (-2147418112), res_sat=0.
- len=3, bias=1, pairs (1,1),(1,1),(1,1) with in_valid gaps of 0, 2 and 4 cycles, res_ready held low 5 cycles, start pulsed while busy → result 4, held stable, extra start ignored; the next start after the handshake runs normally.
- len=5; assert rst_n low after 2 accepted beats, release, then start len=1, bias=0, pair (3,7) → all outputs 0 during reset; no stale result; res_data=21.
